bus_arbiter5: RTL
=================

BUS_ARBITER5 -- requirements
Module: bus_arbiter5

Interface
REQ-001 SHALL have parameter NREQ, default 5, number of requesters; fixed, matches the 5-input operand mux.
REQ-002 SHALL have parameter SEL_W, default 3, width of the mux select.
REQ-003 SHALL have parameter MAX_HOLD, default 16, maximum grant length in cycles; used only when the timeout feature is compiled in.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req, input, 5, per-requester request level; bit i maps to mux data input i.
REQ-007 SHALL have port gnt, output, 5, registered one-hot-or-zero grant.
REQ-008 SHALL have port mux_sel, output, 3, registered select for the 5-input mux; 3'b111 when idle, which makes the mux output zero.
REQ-009 SHALL have port bus_busy, output, 1, high while in GRANT.
REQ-010 SHALL have port timeout, output, 1, one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement three states:
- IDLE
- GRANT
- REL (one-cycle bubble)
REQ-012 SHALL keep a 3-bit round-robin pointer ptr (0..4) naming the highest-priority requester.
REQ-013 In IDLE with any req bit high, SHALL select the first set bit searching ptr, ptr+1, ..., wrapping 4->0.
REQ-014 On that same edge it SHALL enter GRANT, set gnt[idx]=1 and set mux_sel=idx.
REQ-015 Grant latency SHALL be exactly 1 cycle: req sampled at edge N gives gnt visible after edge N.
REQ-016 In IDLE with req==0, SHALL stay in IDLE with gnt=0 and mux_sel=3'b111.
REQ-017 In GRANT, SHALL hold gnt and mux_sel unchanged while req[idx]=1; other req bits SHALL be ignored.
REQ-018 In GRANT with req[idx]=0, SHALL go to REL: gnt=0, mux_sel=3'b111, ptr=(idx+1) mod 5.
REQ-019 From REL, SHALL always go to IDLE; arbitration resumes the next cycle, giving 2 dead cycles between consecutive grants.
REQ-020 SHALL never assert more than one gnt bit; gnt, mux_sel and bus_busy SHALL be mutually consistent in every cycle.
REQ-021 Requests SHALL NOT be latched: a req bit that drops before it is granted is lost.
REQ-022 mux_sel SHALL take only the values 0..4 or 7.

Reset
REQ-023 Asserting reset SHALL asynchronously force:
- state=IDLE
- ptr=0
- gnt=5'b00000
- mux_sel=3'b111
- bus_busy=0
- timeout=0
- hold counter=0
REQ-024 Reset mid-GRANT SHALL drop gnt immediately, without waiting for a clock edge.
REQ-025 After reset deassertion, the first arbitration SHALL start from ptr=0.

Configuration
REQ-026 Macro BUS_ARB_TIMEOUT_EN SHALL compile in an 8-bit hold counter.
REQ-027 With the macro, the counter SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-028 With the macro, when the counter reaches MAX_HOLD-1 with req[idx] still high, the arbiter SHALL go to REL, advance ptr, and pulse timeout for 1 cycle coincident with REL.
REQ-029 With the macro, if req[idx] drops in the same cycle the limit is reached, release SHALL be normal and timeout SHALL stay 0.
REQ-030 Without the macro, grants SHALL be unbounded, no counter SHALL be built, and timeout SHALL be tied to 0.

Verification
REQ-031 Reset, then req=5'b00100 -> one edge later gnt=5'b00100, mux_sel=2, bus_busy=1.
REQ-032 req=5'b11111 held, each owner dropping req after 3 cycles -> grant order 0,1,2,3,4,0 (wrap), with 2 dead cycles between grants.
REQ-033 Owner 4 releases with only req[0] high -> ptr=0, gnt=5'b00001.
REQ-034 reset asserted mid-GRANT between clock edges -> gnt=0 and mux_sel=7 with no clock edge.
REQ-035 With BUS_ARB_TIMEOUT_EN, MAX_HOLD=4, req[1] held -> gnt[1] high for 4 cycles, then timeout=1 for one cycle and ptr=2; req[1] is re-granted only when no other req is pending.
REQ-036 Without the macro, req[3] held for 100 cycles -> gnt[3] stays high and timeout stays 0.

Source files
------------

// File: rtl/bus_arbiter5.sv
// bus_arbiter5: round-robin arbiter driving the select of a 5-input bus mux.
//
// Ports:
//    clk      in   rising-edge clock
//    reset    in   asynchronous active-high reset
//    req      in   per-requester request level (bit i -> mux input i)
//    gnt      out  registered one-hot-or-zero grant
//    mux_sel  out  registered mux select, 0..NREQ-1 while granted, all ones when idle
//    bus_busy out  high while a grant is held
//    timeout  out  one-cycle pulse when a grant is forcibly released
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to limit each grant to MAX_HOLD
// cycles using an 8-bit hold counter. Without it grants are unbounded and
// timeout is tied low.
//
// state   | meaning
// IDLE    | arbitrating; grant issued on the edge a request is seen
// GRANT   | owner holds the bus until its request drops (or hold limit)
// REL     | one-cycle bubble after release before arbitration resumes

module bus_arbiter5 #(
    parameter int NREQ     = 5,
    parameter int SEL_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] mux_sel,
    output logic             bus_busy,
    output logic             timeout
);

    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_GRANT  = 2'd1;
    localparam logic [1:0]       S_REL    = 2'd2;
    localparam logic [SEL_W-1:0] SEL_IDLE = '1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NREQ - 1);

    // The hold counter is 8 bits wide, so the limit must fit in it.
    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
            $error("bus_arbiter5: MAX_HOLD must be in 2..256");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [NREQ-1:0]  r_gnt;
    logic [SEL_W-1:0] r_mux_sel;

    logic             w_found;
    logic [SEL_W-1:0] w_pick;
    logic [SEL_W:0]   w_cand;
    logic             w_owner_req;
    logic [SEL_W-1:0] w_ptr_next;

    // First set request searching ptr, ptr+1, ... with wrap at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_ptr} + (SEL_W+1)'(k);
            if (w_cand >= (SEL_W+1)'(NREQ)) begin
                w_cand = w_cand - (SEL_W+1)'(NREQ);
            end
            if (!w_found && req[w_cand[SEL_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[SEL_W-1:0];
            end
        end
    end

    // mux_sel holds the owner index throughout GRANT.
    assign w_owner_req = req[r_mux_sel];
    assign w_ptr_next  = (r_mux_sel == SEL_LAST) ? '0 : r_mux_sel + 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    logic       r_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_mux_sel <= SEL_IDLE;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state   <= S_GRANT;
                        r_gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                        r_mux_sel <= w_pick;
                        r_hold    <= '0;
                    end
                end
                S_GRANT: begin
                    // A voluntary release in the limit cycle wins: no timeout pulse.
                    if (!w_owner_req || r_hold == 8'(MAX_HOLD - 1)) begin
                        r_state   <= S_REL;
                        r_gnt     <= '0;
                        r_mux_sel <= SEL_IDLE;
                        r_ptr     <= w_ptr_next;
                        r_timeout <= w_owner_req;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                S_REL:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign timeout = r_timeout;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_mux_sel <= SEL_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state   <= S_GRANT;
                        r_gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                        r_mux_sel <= w_pick;
                    end
                end
                S_GRANT: begin
                    if (!w_owner_req) begin
                        r_state   <= S_REL;
                        r_gnt     <= '0;
                        r_mux_sel <= SEL_IDLE;
                        r_ptr     <= w_ptr_next;
                    end
                end
                S_REL:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign timeout = 1'b0;
`endif

    assign gnt      = r_gnt;
    assign mux_sel  = r_mux_sel;
    assign bus_busy = (r_state == S_GRANT);

endmodule
